// File: rtl/vc_input_buffer_if.sv
// Handshake/bus bundle between a virtual-channel input buffer and its
// neighbours: upstream link, route computation, VC allocator and switch allocator.
interface vc_input_buffer_if #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned PORT_SIZE = 3,
  parameter int unsigned VC_SIZE   = 2
);
  logic                 flit_valid_i;
  logic [1:0]           flit_type_i;
  logic [DATA_SIZE-1:0] flit_data_i;
  logic [PORT_SIZE-1:0] route_i;
  logic                 vc_request_o;
  logic [PORT_SIZE-1:0] out_port_o;
  logic                 vc_valid_i;
  logic [VC_SIZE-1:0]   vc_new_i;
  logic [VC_SIZE-1:0]   downstream_vc_o;
  logic                 sa_request_o;
  logic                 sa_grant_i;
  logic [1:0]           flit_type_o;
  logic [DATA_SIZE-1:0] flit_data_o;
  logic                 credit_o;
  logic                 is_idle_o;
  logic                 err_o;

  // Environment side: drives flits, routes and allocator grants.
  modport master (
    output flit_valid_i, flit_type_i, flit_data_i, route_i,
    output vc_valid_i, vc_new_i, sa_grant_i,
    input  vc_request_o, out_port_o, downstream_vc_o, sa_request_o,
    input  flit_type_o, flit_data_o, credit_o, is_idle_o, err_o
  );

  // Buffer side.
  modport slave (
    input  flit_valid_i, flit_type_i, flit_data_i, route_i,
    input  vc_valid_i, vc_new_i, sa_grant_i,
    output vc_request_o, out_port_o, downstream_vc_o, sa_request_o,
    output flit_type_o, flit_data_o, credit_o, is_idle_o, err_o
  );
endinterface

// File: rtl/vc_input_buffer.sv
// Per-VC router input stage: flit FIFO plus IDLE -> VA -> ACTIVE VC state machine.
// Optional sticky protocol checker enabled by VC_INPUT_BUFFER_ERR_CHECK_EN.
module vc_input_buffer #(
  parameter int unsigned BUFFER_SIZE = 8,
  parameter int unsigned DATA_SIZE   = 32,
  parameter int unsigned PORT_NUM    = 5,
  parameter int unsigned PORT_SIZE   = 3,
  parameter int unsigned VC_SIZE     = 2
) (
  input  logic               clk,
  input  logic               rst,
  vc_input_buffer_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] FLIT_HEAD     = 2'b00;
  localparam logic [1:0] FLIT_BODY     = 2'b01;
  localparam logic [1:0] FLIT_TAIL     = 2'b10;
  localparam logic [1:0] FLIT_HEADTAIL = 2'b11;

  if ((BUFFER_SIZE < 2) || ((BUFFER_SIZE & (BUFFER_SIZE - 1)) != 0)) begin : g_bad_depth
    $error("vc_input_buffer: BUFFER_SIZE must be a power of two >= 2");
  end
  if ((1 << PORT_SIZE) < PORT_NUM) begin : g_bad_port
    $error("vc_input_buffer: PORT_SIZE too narrow for PORT_NUM");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VA     = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PORT_SIZE-1:0] out_port_q, out_port_d;
  logic [VC_SIZE-1:0]   downstream_vc_q, downstream_vc_d;
  logic                 vc_request_q, vc_request_d;
  logic                 sa_request_q, sa_request_d;
  logic                 credit_q, credit_d;

  logic [1:0]           type_mem [BUFFER_SIZE];
  logic [DATA_SIZE-1:0] data_mem [BUFFER_SIZE];

  logic       empty, full, push, pop;
  logic [1:0] front_type;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_W'(BUFFER_SIZE));
  assign front_type = type_mem[rd_ptr_q];
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign pop        = (state_q == ST_ACTIVE) && bus.sa_grant_i && !empty;
  assign push       = bus.flit_valid_i && (!full || pop);

  always_comb begin
    state_d         = state_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    out_port_d      = out_port_q;
    downstream_vc_d = downstream_vc_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (!empty && ((front_type == FLIT_HEAD) || (front_type == FLIT_HEADTAIL))) begin
          out_port_d = bus.route_i;
          state_d    = ST_VA;
        end
      end
      ST_VA: begin
        if (bus.vc_valid_i) begin
          downstream_vc_d = bus.vc_new_i;
          state_d         = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (pop && ((front_type == FLIT_TAIL) || (front_type == FLIT_HEADTAIL))) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Request outputs are registered copies of what the next state implies.
    vc_request_d = (state_d == ST_VA);
    sa_request_d = (state_d == ST_ACTIVE) && (count_d != '0);
    credit_d     = pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      out_port_q      <= '0;
      downstream_vc_q <= '0;
      vc_request_q    <= 1'b0;
      sa_request_q    <= 1'b0;
      credit_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      out_port_q      <= out_port_d;
      downstream_vc_q <= downstream_vc_d;
      vc_request_q    <= vc_request_d;
      sa_request_q    <= sa_request_d;
      credit_q        <= credit_d;
    end
  end

  // Storage needs no reset: validity is tracked entirely by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      type_mem[wr_ptr_q] <= bus.flit_type_i;
      data_mem[wr_ptr_q] <= bus.flit_data_i;
    end
  end

  assign bus.vc_request_o    = vc_request_q;
  assign bus.out_port_o      = out_port_q;
  assign bus.downstream_vc_o = downstream_vc_q;
  assign bus.sa_request_o    = sa_request_q;
  assign bus.credit_o        = credit_q;
  assign bus.flit_type_o     = front_type;
  assign bus.flit_data_o     = data_mem[rd_ptr_q];
  assign bus.is_idle_o       = (state_q == ST_IDLE) && empty;

`ifdef VC_INPUT_BUFFER_ERR_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q
          | (bus.flit_valid_i && full && !pop)
          | ((state_q == ST_IDLE) && !empty &&
             ((front_type == FLIT_BODY) || (front_type == FLIT_TAIL)))
          | (bus.sa_grant_i && (empty || (state_q != ST_ACTIVE)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed self-checking bench for vc_input_buffer.
module tb_vc_input_buffer;
  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;
`ifdef VC_INPUT_BUFFER_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic exp_err;

  vc_input_buffer_if #(.DATA_SIZE(32), .PORT_SIZE(3), .VC_SIZE(2)) bus ();

  vc_input_buffer #(
    .BUFFER_SIZE(8), .DATA_SIZE(32), .PORT_NUM(5), .PORT_SIZE(3), .VC_SIZE(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_flit(input logic [1:0] t, input logic [31:0] d);
    bus.flit_valid_i = 1'b1;
    bus.flit_type_i  = t;
    bus.flit_data_i  = d;
    tick();
    bus.flit_valid_i = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_vc_request"}, 64'(bus.vc_request_o), 64'd0);
    chk({tag, "_out_port"},   64'(bus.out_port_o), 64'd0);
    chk({tag, "_ds_vc"},      64'(bus.downstream_vc_o), 64'd0);
    chk({tag, "_sa_request"}, 64'(bus.sa_request_o), 64'd0);
    chk({tag, "_credit"},     64'(bus.credit_o), 64'd0);
    chk({tag, "_err"},        64'(bus.err_o), 64'd0);
    chk({tag, "_is_idle"},    64'(bus.is_idle_o), 64'd1);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_err = 1'b0;
    rst = 1'b1;
    bus.flit_valid_i = 1'b0;
    bus.flit_type_i  = T_HEAD;
    bus.flit_data_i  = '0;
    bus.route_i      = '0;
    bus.vc_valid_i   = 1'b0;
    bus.vc_new_i     = '0;
    bus.sa_grant_i   = 1'b0;

    // Asynchronous reset values, before any clock edge.
    #2;
    chk_reset_outputs("rst0");
    tick();
    rst = 1'b0;
    tick();

    // Single HEADTAIL to port 3, downstream VC 2.
    bus.route_i = 3'd3;
    push_flit(T_HT, 32'hA1);
    chk("ht_req_lat1", 64'(bus.vc_request_o), 64'd0);
    chk("ht_not_idle", 64'(bus.is_idle_o), 64'd0);
    tick();
    chk("ht_req_lat2", 64'(bus.vc_request_o), 64'd1);
    chk("ht_out_port", 64'(bus.out_port_o), 64'd3);
    chk("ht_front",    64'(bus.flit_data_o), 64'hA1);
    chk("ht_type",     64'(bus.flit_type_o), 64'(T_HT));
    bus.route_i = 3'd0;
    tick();
    chk("ht_port_hold", 64'(bus.out_port_o), 64'd3);
    bus.vc_valid_i = 1'b1;
    bus.vc_new_i   = 2'd2;
    tick();
    bus.vc_valid_i = 1'b0;
    chk("ht_ds_vc",    64'(bus.downstream_vc_o), 64'd2);
    chk("ht_sa_req",   64'(bus.sa_request_o), 64'd1);
    chk("ht_req_drop", 64'(bus.vc_request_o), 64'd0);
    bus.sa_grant_i = 1'b1;
    tick();
    bus.sa_grant_i = 1'b0;
    chk("ht_credit",   64'(bus.credit_o), 64'd1);
    chk("ht_idle",     64'(bus.is_idle_o), 64'd1);
    chk("ht_sa_low",   64'(bus.sa_request_o), 64'd0);
    tick();
    chk("ht_credit_end", 64'(bus.credit_o), 64'd0);

    // Four-flit packet, granted every cycle.
    bus.route_i = 3'd1;
    push_flit(T_HEAD, 32'h10);
    push_flit(T_BODY, 32'h11);
    push_flit(T_BODY, 32'h12);
    push_flit(T_TAIL, 32'h13);
    chk("p4_req",  64'(bus.vc_request_o), 64'd1);
    chk("p4_port", 64'(bus.out_port_o), 64'd1);
    bus.vc_valid_i = 1'b1;
    bus.vc_new_i   = 2'd1;
    tick();
    bus.vc_valid_i = 1'b0;
    chk("p4_ds_vc", 64'(bus.downstream_vc_o), 64'd1);
    bus.sa_grant_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("p4_sa_req", 64'(bus.sa_request_o), 64'd1);
      chk("p4_data",   64'(bus.flit_data_o), 64'(32'h10 + i));
      chk("p4_type",   64'(bus.flit_type_o),
          64'((i == 0) ? T_HEAD : ((i == 3) ? T_TAIL : T_BODY)));
      tick();
      chk("p4_credit", 64'(bus.credit_o), 64'd1);
      chk("p4_idle",   64'(bus.is_idle_o), 64'((i == 3) ? 1 : 0));
    end
    bus.sa_grant_i = 1'b0;
    chk("p4_sa_end", 64'(bus.sa_request_o), 64'd0);
    tick();
    chk("p4_credit_end", 64'(bus.credit_o), 64'd0);

    // Back-to-back: HEAD/TAIL then a buffered HEADTAIL to a new port.
    bus.route_i = 3'd2;
    push_flit(T_HEAD, 32'h20);
    push_flit(T_TAIL, 32'h21);
    bus.route_i = 3'd4;
    push_flit(T_HT, 32'h22);
    chk("b2b_port_a", 64'(bus.out_port_o), 64'd2);
    bus.vc_valid_i = 1'b1;
    bus.vc_new_i   = 2'd3;
    tick();
    bus.vc_valid_i = 1'b0;
    bus.sa_grant_i = 1'b1;
    tick();
    chk("b2b_credit_h", 64'(bus.credit_o), 64'd1);
    chk("b2b_front_t",  64'(bus.flit_data_o), 64'h21);
    tick();
    bus.sa_grant_i = 1'b0;
    chk("b2b_idle_req", 64'(bus.vc_request_o), 64'd0);
    chk("b2b_idle_sa",  64'(bus.sa_request_o), 64'd0);
    chk("b2b_not_idle", 64'(bus.is_idle_o), 64'd0);
    chk("b2b_port_old", 64'(bus.out_port_o), 64'd2);
    tick();
    chk("b2b_req_b",  64'(bus.vc_request_o), 64'd1);
    chk("b2b_port_b", 64'(bus.out_port_o), 64'd4);
    bus.vc_valid_i = 1'b1;
    bus.vc_new_i   = 2'd0;
    tick();
    bus.vc_valid_i = 1'b0;
    chk("b2b_ds_vc", 64'(bus.downstream_vc_o), 64'd0);
    bus.sa_grant_i = 1'b1;
    tick();
    bus.sa_grant_i = 1'b0;
    chk("b2b_credit_b", 64'(bus.credit_o), 64'd1);
    chk("b2b_idle_end", 64'(bus.is_idle_o), 64'd1);

    // Fill to 8, drop the 9th push, then push+pop while full.
    bus.route_i = 3'd5;
    push_flit(T_HEAD, 32'h30);
    for (int i = 1; i < 8; i++) push_flit(T_BODY, 32'(32'h30 + i));
    chk("full_err_pre", 64'(bus.err_o), 64'd0);
    push_flit(T_BODY, 32'h99);
    exp_err = ERR_EN;
    tick();
    chk("full_err", 64'(bus.err_o), 64'(exp_err));
    chk("full_req", 64'(bus.vc_request_o), 64'd1);
    bus.vc_valid_i = 1'b1;
    bus.vc_new_i   = 2'd2;
    tick();
    bus.vc_valid_i = 1'b0;
    chk("full_front0", 64'(bus.flit_data_o), 64'h30);
    bus.flit_valid_i = 1'b1;
    bus.flit_type_i  = T_TAIL;
    bus.flit_data_i  = 32'h40;
    bus.sa_grant_i   = 1'b1;
    tick();
    bus.flit_valid_i = 1'b0;
    chk("full_pp_credit", 64'(bus.credit_o), 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk("full_data", 64'(bus.flit_data_o), 64'((i < 7) ? (32'h31 + i) : 32'h40));
      tick();
      chk("full_credit", 64'(bus.credit_o), 64'd1);
    end
    bus.sa_grant_i = 1'b0;
    chk("full_idle_end", 64'(bus.is_idle_o), 64'd1);
    chk("full_err_hold", 64'(bus.err_o), 64'(exp_err));
    tick();

    // Reset while in VA with three flits buffered.
    bus.route_i = 3'd5;
    push_flit(T_HEAD, 32'h50);
    push_flit(T_BODY, 32'h51);
    push_flit(T_BODY, 32'h52);
    chk("mid_req",  64'(bus.vc_request_o), 64'd1);
    chk("mid_port", 64'(bus.out_port_o), 64'd5);
    chk("mid_ds",   64'(bus.downstream_vc_o), 64'd2);
    rst = 1'b1;
    exp_err = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    tick();
    chk("mid_rst_credit", 64'(bus.credit_o), 64'd0);
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_idle",   64'(bus.is_idle_o), 64'd1);
    chk("post_rst_req",    64'(bus.vc_request_o), 64'd0);
    chk("post_rst_credit", 64'(bus.credit_o), 64'd0);
    chk("post_rst_err",    64'(bus.err_o), 64'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
